multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM sequencing the fetch/decode datapath (PC, instruction ROM, IR, decoder)

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/alu_op_decode.sv | 46 ++++
 rtl/multicycle_ctrl.sv | 139 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode, state, alu_op, pc_src and wb_sel encodings for the multi-cycle control FSM
package ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_REL   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_L, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode/funct3/funct7 to ALU operation decode
module alu_op_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op
);

    logic    alt;
    alu_op_t op;

    // Only the exact 0100000 pattern selects SUB/SRA; other funct7 values take the base op.
    assign alt = (funct7 == 7'b0100000);

    always_comb begin
        op = ALU_ADD;
        case (opcode)
            OP_R, OP_I: begin
                case (funct3)
                    3'b000:  op = (opcode == OP_R && alt) ? ALU_SUB : ALU_ADD;
                    3'b001:  op = ALU_SLL;
                    3'b010:  op = ALU_SLT;
                    3'b011:  op = ALU_SLTU;
                    3'b100:  op = ALU_XOR;
                    3'b101:  op = alt ? ALU_SRA : ALU_SRL;
                    3'b110:  op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
            OP_B: begin
                case (funct3)
                    3'b100, 3'b101: op = ALU_SLT;
                    3'b110, 3'b111: op = ALU_SLTU;
                    default:        op = ALU_SUB;
                endcase
            end
            OP_LUI:  op = ALU_PASS_B;
            default: op = ALU_ADD;
        endcase
    end

    assign alu_op = op;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB) with retired-instruction counter
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MEM_WAIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             ir_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [3:0]       alu_op,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t     state, state_nxt;
    logic       retire;
    logic       br_taken;
    logic [3:0] dec_op;

    alu_op_decode u_dec (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .alu_op (dec_op)
    );

    // Datapath registers update on the falling edge, so the FSM does too.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (retire) retired <= retired + 1'b1;
        end
    end

    // zero reflects SUB for BEQ/BNE and SLT/SLTU (result 1 -> zero=0) for the ordered compares.
    always_comb begin
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = ~zero;
            3'b100:  br_taken = ~zero;
            3'b101:  br_taken = zero;
            3'b110:  br_taken = ~zero;
            3'b111:  br_taken = zero;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        pc_src    = PC_PLUS4;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        halted    = 1'b0;

        case (state)
            ST_IDLE: if (run) state_nxt = ST_IF;
            ST_IF: begin
                pc_write  = 1'b1;
                ir_write  = 1'b1;
                state_nxt = ST_ID;
            end
            ST_ID: state_nxt = is_legal(opcode) ? ST_EX : ST_HALT;
            ST_EX: begin
                alu_op = dec_op;
                case (opcode)
                    OP_I, OP_L, OP_S, OP_LUI: alu_src_b = 1'b1;
                    OP_AUIPC: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                    end
                    OP_JAL: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = PC_REL;
                    end
                    OP_JALR: begin
                        alu_src_b = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = PC_JALR;
                    end
                    OP_B: begin
                        pc_write = br_taken;
                        pc_src   = br_taken ? PC_REL : PC_PLUS4;
                    end
                    default: ;
                endcase
                if (opcode == OP_L || opcode == OP_S) state_nxt = ST_MEM;
                else if (opcode == OP_B)              retire    = 1'b1;
                else                                  state_nxt = ST_WB;
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_S);
                if (MEM_WAIT == 0 || mem_ack) begin
                    if (opcode == OP_S) retire    = 1'b1;
                    else                state_nxt = ST_WB;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                if (opcode == OP_L)                           wb_sel = WB_MEM;
                else if (opcode == OP_JAL || opcode == OP_JALR) wb_sel = WB_PC4;
                retire = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase

        if (retire) state_nxt = run ? ST_IF : ST_IDLE;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_SLTU = 4'd4;
    localparam logic [3:0] A_SRA  = 4'd7;

    logic        clk = 1'b0;
    logic        rst_n, run, zero, mem_ack;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        pc_write, ir_write, alu_src_a, alu_src_b, mem_req, mem_we, reg_write, halted;
    logic [1:0]  pc_src, wb_sel;
    logic [3:0]  alu_op;
    logic [31:0] retired;
    logic [15:0] ctl;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.CNT_W(32), .MEM_WAIT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .zero      (zero),
        .mem_ack   (mem_ack),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_write, ir_write, pc_src, alu_src_a, alu_src_b, alu_op,
                  mem_req, mem_we, reg_write, wb_sel, halted};

    function automatic logic [15:0] mk(input logic pw, input logic iw, input logic [1:0] ps,
                                       input logic a, input logic b, input logic [3:0] op,
                                       input logic mr, input logic mw, input logic rw,
                                       input logic [1:0] ws, input logic h);
        return {pw, iw, ps, a, b, op, mr, mw, rw, ws, h};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FSM moves on negedge; sample and drive just after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_insn(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; zero = 1'b0; mem_ack = 1'b0;
        set_insn(7'h00, 3'h0, 7'h00);
        step(); step();
        chk("reset_ctl", {16'h0, ctl}, 32'h0);
        chk("reset_retired", retired, 32'd0);

        // ADD x3,x1,x2 (0x002081B3)
        rst_n = 1'b1; run = 1'b1;
        set_insn(7'b0110011, 3'b000, 7'b0000000);
        step(); chk("add_if", {16'h0, ctl}, {16'h0, mk(1,1,2'd0,0,0,A_ADD,0,0,0,2'd0,0)});
        step(); chk("add_id", {16'h0, ctl}, 32'h0);
        step(); chk("add_ex", {16'h0, ctl}, {16'h0, mk(0,0,2'd0,0,0,A_ADD,0,0,0,2'd0,0)});
        step(); chk("add_wb", {16'h0, ctl}, {16'h0, mk(0,0,2'd0,0,0,4'd0,0,0,1,2'd0,0)});
        chk("add_wb_retired", retired, 32'd0);

        // LW (0x0000A183); mem_ack raised in ID must be ignored
        step(); chk("lw_if", {16'h0, ctl}, {16'h0, mk(1,1,2'd0,0,0,4'd0,0,0,0,2'd0,0)});
        chk("add_retired", retired, 32'd1);
        set_insn(7'b0000011, 3'b010, 7'b0000000);
        step(); chk("lw_id", {16'h0, ctl}, 32'h0);
        mem_ack = 1'b1;
        step(); chk("lw_ex", {16'h0, ctl}, {16'h0, mk(0,0,2'd0,0,1,A_ADD,0,0,0,2'd0,0)});
        mem_ack = 1'b0;
        step(); chk("lw_mem1", {16'h0, ctl}, {16'h0, mk(0,0,2'd0,0,0,4'd0,1,0,0,2'd0,0)});
        step(); chk("lw_mem2", {16'h0, ctl}, {16'h0, mk(0,0,2'd0,0,0,4'd0,1,0,0,2'd0,0)});
        step(); chk("lw_mem3", {16'h0, ctl}, {16'h0, mk(0,0,2'd0,0,0,4'd0,1,0,0,2'd0,0)});
        mem_ack = 1'b1;
        step(); chk("lw_wb", {16'h0, ctl}, {16'h0, mk(0,0,2'd0,0,0,4'd0,0,0,1,2'd1,0)});
        mem_ack = 1'b0;

        // BEQ taken (zero=1)
        step(); chk("beq_t_if", {16'h0, ctl}, {16'h0, mk(1,1,2'd0,0,0,4'd0,0,0,0,2'd0,0)});
        chk("lw_retired", retired, 32'd2);
        set_insn(7'b1100011, 3'b000, 7'b0000000); zero = 1'b1;
        step(); chk("beq_t_id", {16'h0, ctl}, 32'h0);
        step(); chk("beq_t_ex", {16'h0, ctl}, {16'h0, mk(1,0,2'd1,0,0,A_SUB,0,0,0,2'd0,0)});

        // BEQ not taken (zero=0)
        step(); chk("beq_n_if", {16'h0, ctl}, {16'h0, mk(1,1,2'd0,0,0,4'd0,0,0,0,2'd0,0)});
        chk("beq_t_retired", retired, 32'd3);
        zero = 1'b0;
        step(); chk("beq_n_id", {16'h0, ctl}, 32'h0);
        step(); chk("beq_n_ex", {16'h0, ctl}, {16'h0, mk(0,0,2'd0,0,0,A_SUB,0,0,0,2'd0,0)});

        // BLTU with SLTU result 1 (zero=0) is taken
        step(); chk("bltu_if", {16'h0, ctl}, {16'h0, mk(1,1,2'd0,0,0,4'd0,0,0,0,2'd0,0)});
        chk("beq_n_retired", retired, 32'd4);
        set_insn(7'b1100011, 3'b110, 7'b0000000);
        step(); chk("bltu_id", {16'h0, ctl}, 32'h0);
        step(); chk("bltu_ex", {16'h0, ctl}, {16'h0, mk(1,0,2'd1,0,0,A_SLTU,0,0,0,2'd0,0)});

        // SRAI, run dropped during WB -> completes and parks in IDLE
        step(); chk("srai_if", {16'h0, ctl}, {16'h0, mk(1,1,2'd0,0,0,4'd0,0,0,0,2'd0,0)});
        chk("bltu_retired", retired, 32'd5);
        set_insn(7'b0010011, 3'b101, 7'b0100000);
        step(); chk("srai_id", {16'h0, ctl}, 32'h0);
        step(); chk("srai_ex", {16'h0, ctl}, {16'h0, mk(0,0,2'd0,0,1,A_SRA,0,0,0,2'd0,0)});
        step(); chk("srai_wb", {16'h0, ctl}, {16'h0, mk(0,0,2'd0,0,0,4'd0,0,0,1,2'd0,0)});
        run = 1'b0;
        step(); chk("idle_after_srai", {16'h0, ctl}, 32'h0);
        chk("srai_retired", retired, 32'd6);
        step(); chk("idle_stays", {16'h0, ctl}, 32'h0);

        // ADD again, reset asserted mid-EX
        run = 1'b1;
        set_insn(7'b0110011, 3'b000, 7'b0000000);
        step(); chk("add2_if", {16'h0, ctl}, {16'h0, mk(1,1,2'd0,0,0,4'd0,0,0,0,2'd0,0)});
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("midreset_ctl", {16'h0, ctl}, 32'h0);
        chk("midreset_retired", retired, 32'd0);
        step(); chk("reset_held_ctl", {16'h0, ctl}, 32'h0);

        // Illegal opcode 0x7F -> HALT after ID
        rst_n = 1'b1;
        set_insn(7'h7F, 3'b000, 7'b0000000);
        step(); chk("ill_if", {16'h0, ctl}, {16'h0, mk(1,1,2'd0,0,0,4'd0,0,0,0,2'd0,0)});
        step(); chk("ill_id", {16'h0, ctl}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            run     = i[0];
            mem_ack = 1'b1;
            step();
            chk("halt_ctl", {16'h0, ctl}, {16'h0, mk(0,0,2'd0,0,0,4'd0,0,0,0,2'd0,1)});
            chk("halt_retired", retired, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
